// File: rtl/proc_zbt_wr_buf.sv
// Write buffer between the edge-processing stage and ZBT bank 1: a 16-entry FIFO
// drained only in arbiter-granted slots, merging repeated pushes to the same address.
module proc_zbt_wr_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DAT_W      = 36,
    parameter int ADDR_W     = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DAT_W-1:0]      two_proc_pixs,
    input  logic [ADDR_W-1:0]     proc_pix_addr,
    input  logic                  wr_slot,
    output logic                  zbt_we,
    output logic [ADDR_W-1:0]     zbt_addr,
    output logic [DAT_W-1:0]      zbt_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DAT_W-1:0]      mem_dat  [DEPTH];
    logic [ADDR_W-1:0]     mem_addr [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] tail_ptr;
    logic [ADDR_W-1:0]     last_addr;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  merge;
    logic                  append;
    logic                  drop;
    logic [DEPTH_LOG2:0]   level_nxt;

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_FULL);
    assign tail_ptr = wr_ptr - PTR_ONE;
    assign pop      = wr_slot && !empty;

    // A lone entry that leaves this edge cannot absorb a merge; the push must append instead.
    assign merge  = in_valid && !empty && (proc_pix_addr == last_addr)
                    && !((level == LEVEL_ONE) && pop);
    assign append = in_valid && !merge && (!full || pop);
    assign drop   = in_valid && !merge && full && !pop;

    always_comb begin
        level_nxt = level;
        if (append && !pop) begin
            level_nxt = level + LEVEL_ONE;
        end else if (pop && !append) begin
            level_nxt = level - LEVEL_ONE;
        end
    end

    // Storage carries no reset; validity is tracked entirely by level and the pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (append) begin
                mem_dat[wr_ptr]  <= two_proc_pixs;
                mem_addr[wr_ptr] <= proc_pix_addr;
            end else if (merge) begin
                mem_dat[tail_ptr] <= two_proc_pixs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_addr <= '0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            level <= level_nxt;
            if (append) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                last_addr <= proc_pix_addr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zbt_we   <= 1'b0;
            zbt_addr <= '0;
            zbt_data <= '0;
        end else begin
            zbt_we <= pop;
            if (pop) begin
                zbt_addr <= mem_addr[rd_ptr];
                zbt_data <= mem_dat[rd_ptr];
            end
        end
    end

endmodule
